// File: rtl/dadda_mac_seq_pkg.sv
// rtl/dadda_mac_seq_pkg.sv - shared constants and FSM encoding for the Dadda MAC sequencer
package dadda_mac_seq_pkg;

  localparam int ACC_W = 16;
  localparam int OP_W  = 8;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_MUL    = 2'd1,
    ST_ADD    = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/dadda_mac_seq_if.sv
// rtl/dadda_mac_seq_if.sv - operand stream and result stream bundle for the MAC sequencer
interface dadda_mac_seq_if #(
  parameter int CNT_W = 8
);
  import dadda_mac_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             in_last;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;
  logic [CNT_W-1:0] res_cnt;
  logic             res_trunc;

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready,
    input  in_ready, res_valid, res_data, res_ovf, res_cnt, res_trunc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready,
    output in_ready, res_valid, res_data, res_ovf, res_cnt, res_trunc
  );

endinterface

// File: rtl/dadda_mac_seq_carryseladd.sv
// rtl/dadda_mac_seq_carryseladd.sv - 16-bit carry-select adder resolving the carry-save rows
module dadda_mac_seq_carryseladd
  import dadda_mac_seq_pkg::*;
(
  input  logic [ACC_W-1:0] x,
  input  logic [ACC_W-1:0] y,
  output logic [ACC_W:0]   sum
);

  localparam int H = ACC_W / 2;

  logic [H:0] lo;
  logic [H:0] hi0;
  logic [H:0] hi1;

  // Upper half is precomputed for both carry-ins; the low half's carry picks one.
  always_comb begin
    lo  = {1'b0, x[H-1:0]} + {1'b0, y[H-1:0]};
    hi0 = {1'b0, x[ACC_W-1:H]} + {1'b0, y[ACC_W-1:H]};
    hi1 = {1'b0, x[ACC_W-1:H]} + {1'b0, y[ACC_W-1:H]} + {{H{1'b0}}, 1'b1};
    sum = lo[H] ? {hi1, lo[H-1:0]} : {hi0, lo[H-1:0]};
  end

endmodule

// File: rtl/dadda_mac_seq.sv
// rtl/dadda_mac_seq.sv - sequences operand pairs through the external Dadda array and accumulates
module dadda_mac_seq
  import dadda_mac_seq_pkg::*;
#(
  parameter int               CNT_W    = 8,
  parameter int               SAT      = 0,
  parameter logic [ACC_W-1:0] ACC_INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  dadda_mac_seq_if.slave    bus,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic [ACC_W-1:0]  mul_acc,
  input  logic [ACC_W-1:0]  row0,
  input  logic [ACC_W-1:0]  row1
);

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   row0_q;
  logic [ACC_W-1:0]   row1_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_q;
  logic               ovf;
  logic               trunc;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_next;
  logic               limit;

  dadda_mac_seq_carryseladd u_csa (
    .x   (row0_q),
    .y   (row1_q),
    .sum (sum)
  );

  always_comb begin
    cnt_inc  = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    limit    = (cnt_inc == {CNT_W{1'b1}});
    acc_next = (sum[ACC_W] && (SAT != 0)) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACCEPT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCEPT: if (bus.in_valid) state_next = ST_MUL;
      ST_MUL:    state_next = ST_ADD;
      ST_ADD:    state_next = (last_q || limit) ? ST_OUT : ST_ACCEPT;
      ST_OUT:    if (bus.res_ready) state_next = ST_ACCEPT;
      default:   state_next = ST_ACCEPT;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ST_ACCEPT);
    bus.res_valid = (state == ST_OUT);
    bus.res_data  = (state == ST_OUT) ? mul_acc : '0;
    bus.res_ovf   = ovf;
    bus.res_cnt   = cnt;
    bus.res_trunc = trunc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= ACC_INIT;
      row0_q  <= '0;
      row1_q  <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      ovf     <= 1'b0;
      trunc   <= 1'b0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (bus.in_valid) begin
            mul_a  <= bus.in_a;
            mul_b  <= bus.in_b;
            last_q <= bus.in_last;
          end
        end
        ST_MUL: begin
          row0_q <= row0;
          row1_q <= row1;
        end
        ST_ADD: begin
          mul_acc <= acc_next;
          ovf     <= ovf | sum[ACC_W];
          cnt     <= cnt_inc;
          trunc   <= limit & ~last_q;
        end
        ST_OUT: begin
          // Result handoff rearms the accumulator for the next packet.
          if (bus.res_ready) begin
            mul_acc <= ACC_INIT;
            cnt     <= '0;
            ovf     <= 1'b0;
            trunc   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_mac_seq.sv
// tb/tb_dadda_mac_seq.sv - directed bench for dadda_mac_seq with a behavioural array model
module tb_dadda_mac_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dadda_mac_seq_if #(.CNT_W(8)) if0 ();
  dadda_mac_seq_if #(.CNT_W(8)) if1 ();
  dadda_mac_seq_if #(.CNT_W(2)) if2 ();

  logic [7:0]  ma0, mb0, ma1, mb1, ma2, mb2;
  logic [15:0] macc0, macc1, macc2;
  logic [15:0] r00, r10, r01, r11, r02, r12;

  // Array model: product on one row, accumulator on the other; the rows sum to a*b+acc.
  assign r00 = {8'd0, ma0} * {8'd0, mb0};
  assign r10 = macc0;
  assign r01 = {8'd0, ma1} * {8'd0, mb1};
  assign r11 = macc1;
  assign r02 = {8'd0, ma2} * {8'd0, mb2};
  assign r12 = macc2;

  // Saturating instance mirrors the wrapping instance's stimulus.
  assign if1.in_valid  = if0.in_valid;
  assign if1.in_a      = if0.in_a;
  assign if1.in_b      = if0.in_b;
  assign if1.in_last   = if0.in_last;
  assign if1.res_ready = if0.res_ready;

  dadda_mac_seq #(.CNT_W(8), .SAT(0), .ACC_INIT(16'h0000)) u0 (
    .clk(clk), .rst(rst), .bus(if0), .mul_a(ma0), .mul_b(mb0), .mul_acc(macc0), .row0(r00), .row1(r10));
  dadda_mac_seq #(.CNT_W(8), .SAT(1), .ACC_INIT(16'h0000)) u1 (
    .clk(clk), .rst(rst), .bus(if1), .mul_a(ma1), .mul_b(mb1), .mul_acc(macc1), .row0(r01), .row1(r11));
  dadda_mac_seq #(.CNT_W(2), .SAT(0), .ACC_INIT(16'h0000)) u2 (
    .clk(clk), .rst(rst), .bus(if2), .mul_a(ma2), .mul_b(mb2), .mul_acc(macc2), .row0(r02), .row1(r12));

  typedef struct {
    int       n;
    bit [7:0] a [4];
    bit [7:0] b [4];
    int       d_wrap;
    int       o_wrap;
    int       d_sat;
    int       o_sat;
    int       cnt;
  } vec_t;

  vec_t vecs [5];
  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic put_term(input bit [7:0] a, input bit [7:0] b, input bit last);
    int t = 0;
    if0.in_valid = 1'b1;
    if0.in_a = a;
    if0.in_b = b;
    if0.in_last = last;
    while (!if0.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_ready", int'(if0.in_ready), 1);
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input int d0, input int o0, input int c0,
                          input int tr, input int d1, input int o1);
    int t = 0;
    while (!if0.res_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_valid"}, int'(if0.res_valid), 1);
    chk({nm, "_data"},  int'(if0.res_data), d0);
    chk({nm, "_ovf"},   int'(if0.res_ovf), o0);
    chk({nm, "_cnt"},   int'(if0.res_cnt), c0);
    chk({nm, "_trunc"}, int'(if0.res_trunc), tr);
    chk({nm, "_sat_data"}, int'(if1.res_data), d1);
    chk({nm, "_sat_ovf"},  int'(if1.res_ovf), o1);
  endtask

  task automatic consume();
    if0.res_ready = 1'b1;
    @(posedge clk); #1;
    if0.res_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_in_ready"}, int'(if0.in_ready), 1);
    chk({nm, "_res_valid"}, int'(if0.res_valid), 0);
    chk({nm, "_res_data"}, int'(if0.res_data), 0);
    chk({nm, "_res_ovf"}, int'(if0.res_ovf), 0);
    chk({nm, "_res_cnt"}, int'(if0.res_cnt), 0);
    chk({nm, "_res_trunc"}, int'(if0.res_trunc), 0);
    chk({nm, "_mul_a"}, int'(ma0), 0);
    chk({nm, "_mul_b"}, int'(mb0), 0);
    chk({nm, "_mul_acc"}, int'(macc0), 0);
  endtask

  initial begin
    vecs[0] = '{n: 1, a: '{0, 0, 0, 0}, b: '{0, 0, 0, 0}, d_wrap: 0, o_wrap: 0, d_sat: 0, o_sat: 0, cnt: 1};
    vecs[1] = '{n: 4, a: '{255, 255, 255, 255}, b: '{255, 255, 255, 255},
                d_wrap: 63492, o_wrap: 1, d_sat: 65535, o_sat: 1, cnt: 4};
    vecs[2] = '{n: 2, a: '{10, 0, 0, 0}, b: '{20, 0, 0, 0}, d_wrap: 200, o_wrap: 0, d_sat: 200, o_sat: 0, cnt: 2};
    vecs[3] = '{n: 3, a: '{200, 150, 100, 0}, b: '{100, 200, 150, 0},
                d_wrap: 65000, o_wrap: 0, d_sat: 65000, o_sat: 0, cnt: 3};
    vecs[4] = '{n: 2, a: '{255, 255, 0, 0}, b: '{255, 3, 0, 0}, d_wrap: 254, o_wrap: 1, d_sat: 65535, o_sat: 1, cnt: 2};

    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.in_last = 1'b0; if0.res_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.in_last = 1'b0; if2.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("rst");

    // Single term with exact latency
    put_term(8'd3, 8'd5, 1'b1);
    chk("lat_mul", int'(if0.res_valid), 0);
    @(posedge clk); #1;
    chk("lat_add", int'(if0.res_valid), 0);
    @(posedge clk); #1;
    chk("lat_out", int'(if0.res_valid), 1);
    wait_res("single", 15, 0, 1, 0, 15, 0);
    consume();

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        put_term(vecs[v].a[i], vecs[v].b[i], i == vecs[v].n - 1);
      wait_res($sformatf("vec%0d", v), vecs[v].d_wrap, vecs[v].o_wrap, vecs[v].cnt, 0,
               vecs[v].d_sat, vecs[v].o_sat);
      consume();
    end

    // Back-to-back stream with in_valid held high
    begin
      bit [7:0] ta [3] = '{1, 3, 5};
      bit [7:0] tb [3] = '{2, 4, 6};
      int k = 0;
      if0.in_valid = 1'b1;
      if0.in_a = ta[0]; if0.in_b = tb[0]; if0.in_last = 1'b0;
      for (int cyc = 0; cyc < 9; cyc++) begin
        bit acc_now;
        chk($sformatf("stream_ready%0d", cyc), int'(if0.in_ready), (cyc % 3 == 0) ? 1 : 0);
        acc_now = if0.in_ready;
        @(posedge clk); #1;
        if (acc_now) begin
          k++;
          if (k < 3) begin
            if0.in_a = ta[k]; if0.in_b = tb[k]; if0.in_last = (k == 2);
          end else begin
            if0.in_valid = 1'b0;
          end
        end
      end
    end
    wait_res("stream", 44, 0, 3, 0, 44, 0);

    // Backpressure, then handoff with a new operand already offered
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", c), int'(if0.res_valid), 1);
      chk($sformatf("bp_data%0d", c), int'(if0.res_data), 44);
      chk($sformatf("bp_in_ready%0d", c), int'(if0.in_ready), 0);
    end
    if0.in_valid = 1'b1; if0.in_a = 8'd2; if0.in_b = 8'd2; if0.in_last = 1'b1;
    consume();
    chk("handoff_in_ready", int'(if0.in_ready), 1);
    chk("handoff_res_valid", int'(if0.res_valid), 0);
    chk("handoff_no_accept", int'(ma0), 5);
    chk("handoff_cnt_clr", int'(if0.res_cnt), 0);
    put_term(8'd2, 8'd2, 1'b1);
    wait_res("after_bp", 4, 0, 1, 0, 4, 0);
    consume();

    // Reset during ADD of the second term
    put_term(8'd10, 8'd10, 1'b0);
    put_term(8'd20, 8'd20, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("midrst");
    repeat (4) @(posedge clk);
    #1 chk("midrst_no_result", int'(if0.res_valid), 0);
    put_term(8'd7, 8'd7, 1'b1);
    wait_res("post_rst", 49, 0, 1, 0, 49, 0);
    consume();

    // Counter limit on the 2-bit instance
    for (int k = 0; k < 3; k++) begin
      int t = 0;
      if2.in_valid = 1'b1; if2.in_a = 8'd1; if2.in_b = 8'd1; if2.in_last = 1'b0;
      while (!if2.in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      chk($sformatf("lim_accept%0d", k), int'(if2.in_ready), 1);
      @(posedge clk); #1;
      if2.in_valid = 1'b0;
    end
    begin
      int t = 0;
      while (!if2.res_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk("lim_valid", int'(if2.res_valid), 1);
    chk("lim_data", int'(if2.res_data), 3);
    chk("lim_cnt", int'(if2.res_cnt), 3);
    chk("lim_trunc", int'(if2.res_trunc), 1);
    if2.res_ready = 1'b1;
    @(posedge clk); #1;
    if2.res_ready = 1'b0;
    chk("lim_trunc_clr", int'(if2.res_trunc), 0);
    chk("lim_in_ready", int'(if2.in_ready), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dadda_mac_seq.md
Name: dadda_mac_seq

Overview:
- Sequencing and accumulation stage wrapped around the combinational 8x8 Dadda MAC array.
- Accepts a stream of unsigned 8-bit operand pairs (valid/ready) and drives the array's operand and accumulator inputs from registers.
- Captures the array's two 16-bit carry-save rows and resolves them with the 16-bit carry-select adder (carryseladd).
- Feeds the sum back as the next accumulator value and emits one dot-product result per packet (valid/ready).

Parameters:
CNT_W, 8, width of term counter; max terms per packet = 2^CNT_W - 1
SAT, 0, 0 = accumulator wraps mod 2^16 on overflow; 1 = saturates at 16'hFFFF
ACC_INIT, 16'h0000, accumulator value loaded at reset and at start of each packet

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair
in_a  input  8  multiplicand
in_b  input  8  multiplier
in_last  input  1  final term of packet
mul_a  output  8  to array inp1 (registered)
mul_b  output  8  to array inp2 (registered)
mul_acc  output  16  to array acc (registered accumulator)
row0  input  16  array carry-save row prod4_0
row1  input  16  array carry-save row prod4_1
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
res_data  output  16  accumulated dot product
res_ovf  output  1  sticky: any term addition produced carry-out
res_cnt  output  CNT_W  number of terms accumulated
res_trunc  output  1  packet force-closed by counter limit

Behaviour:
- Reset (rst=1 at edge): state=ACCEPT, in_ready=1, res_valid=0, res_data=0, res_ovf=0, res_cnt=0, res_trunc=0, mul_a=0, mul_b=0, mul_acc=ACC_INIT, rows register=0, term counter=0, last flag=0. Reset mid-packet discards in-flight term and partial sum; no result is emitted for that packet.
- FSM states: ACCEPT, MUL, ADD, OUT.
- ACCEPT: in_ready=1.
  - in_valid=1: load mul_a/mul_b from in_a/in_b, latch in_last, go to MUL.
  - Otherwise hold state.
- MUL: in_ready=0. Array evaluates from registered mul_a/mul_b/mul_acc. At the edge, capture row0/row1 into the rows register; go to ADD.
- ADD: in_ready=0. carryseladd sums the rows register to a 17-bit result. At the edge:
  - Accumulator: if sum[16]=0, acc=sum[15:0]. If sum[16]=1, acc=sum[15:0] when SAT=0, 16'hFFFF when SAT=1.
  - Once saturated (SAT=1), the accumulator stays 16'hFFFF for the rest of the packet.
  - Overflow: ovf_sticky |= sum[16]; counter += 1.
  - Next state: OUT if latched last=1 or counter reaches 2^CNT_W-1 (then res_trunc=1); else ACCEPT.
- Throughput: one term per 3 cycles. Latency from the accepting edge of the last term to res_valid=1: exactly 3 edges (MUL, ADD, OUT entry).
- OUT: res_valid=1; res_data/res_ovf/res_cnt/res_trunc held stable while res_ready=0.
  - res_valid and res_ready both 1 at an edge: result consumed. Reload mul_acc=ACC_INIT, clear counter, ovf and trunc; go to ACCEPT (in_ready=1 the next cycle).
  - No new operand is accepted in the same cycle as result handoff.
- Outputs mul_a/mul_b/mul_acc change only at ACCEPT→MUL and ADD edges. The array plus the adder path must settle within one clock period each; the clock period is set by the timing analysis.
- Width rules: all arithmetic is unsigned; the 17-bit sum is never truncated before the overflow check.
- in_valid during MUL/ADD/OUT is ignored. The upstream must hold data until in_ready.

Decomposition:
- Shared package: FSM state encoding (ACCEPT=2'd0, MUL=2'd1, ADD=2'd2, OUT=2'd3), ACC_W=16, OP_W=8 constants.
- One sub-module instance: carryseladd for the row resolution.
- The array itself stays outside; integration pairs it with this block at top level.

Test Plan:
- Single term: a=3, b=5, last=1, ACC_INIT=0 → res_valid 3 edges after accept; res_data=15, res_ovf=0, res_cnt=1, res_trunc=0.
- Four terms, each a=255, b=255, last on 4th, SAT=0 → res_data=63492 (260100 mod 65536), res_ovf=1, res_cnt=4. Same with SAT=1 → res_data=65535, res_ovf=1.
- Back-to-back stream with in_valid held high: in_ready pattern 1,0,0 repeating. Terms (1,2),(3,4),(5,6)+last → res_data=44.
- Backpressure: res_ready=0 for 5 cycles → res_valid held, res_data stable, in_ready=0. res_ready=1 → in_ready=1 the following cycle; next packet (2,2,last) gives res_data=4 (accumulator reset confirmed).
- Reset mid-operation: assert rst during ADD of 2nd term of a (10,10),(20,20) packet → all outputs return to reset values; new packet (7,7,last) gives res_data=49, res_cnt=1.
- Counter limit with CNT_W=2: 3 terms of (1,1) without last → res_valid after 3rd term; res_data=3, res_cnt=3, res_trunc=1.
